mem_xbar_hs: RTL

- N-target memory crossbar with a request/grant handshake. Successor to the fixed two-region combinational crossbar.
- Sits between the CPU load/store unit (single initiator) and N word-addressed targets (DMEM, MMIO, boot ROM, ...).
- Supports one outstanding transaction and variable-latency targets. Unmapped addresses get a registered bus-error response.

---
 rtl/mem_xbar_pkg.sv | 23 ++
 rtl/mem_xbar_hs_if.sv | 41 ++++
 rtl/mem_xbar_hs_dec.sv | 43 ++++
 rtl/mem_xbar_hs.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_xbar_pkg.sv
// Shared definitions for the handshake memory crossbar: FSM encoding,
// default bus widths and a constant clog2 helper.
package mem_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_xbar_hs_if.sv
// Initiator and target-side signal bundle of the crossbar. The slave modport
// is the crossbar's view, the master modport is the environment's view.
interface mem_xbar_hs_if #(
  parameter int N_TGT  = 2,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic                    i_req;
  logic                    o_gnt;
  logic [ADDR_W-1:0]       i_addr;
  logic [DATA_W-1:0]       i_data;
  logic                    i_wren;
  logic [MASK_W-1:0]       i_mask;
  logic                    o_rvalid;
  logic [DATA_W-1:0]       o_rdata;
  logic                    o_err;

  logic [N_TGT-1:0]        o_t_req;
  logic [N_TGT-1:0]        i_t_gnt;
  logic [ADDR_W-1:0]       o_t_addr;
  logic [DATA_W-1:0]       o_t_data;
  logic                    o_t_wren;
  logic [MASK_W-1:0]       o_t_mask;
  logic [N_TGT-1:0]        i_t_rvalid;
  logic [N_TGT*DATA_W-1:0] i_t_rdata;

  modport slave (
    input  i_req, i_addr, i_data, i_wren, i_mask, i_t_gnt, i_t_rvalid, i_t_rdata,
    output o_gnt, o_rvalid, o_rdata, o_err,
    output o_t_req, o_t_addr, o_t_data, o_t_wren, o_t_mask
  );

  modport master (
    output i_req, i_addr, i_data, i_wren, i_mask, i_t_gnt, i_t_rvalid, i_t_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_err,
    input  o_t_req, o_t_addr, o_t_data, o_t_wren, o_t_mask
  );

endinterface

// File: rtl/mem_xbar_hs_dec.sv
// Combinational address decoder: [base, limit) range match per region,
// lowest index wins on overlap, offset is relative to the winning base.
module mem_xbar_hs_dec
  import mem_xbar_pkg::*;
#(
  parameter int                      N_TGT     = 2,
  parameter int                      ADDR_W    = DEF_ADDR_W,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE  = '0,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_LIMIT = '0,
  localparam int                     IDX_W     = (N_TGT > 1) ? clog2(N_TGT) : 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [N_TGT-1:0]  o_sel,
  output logic [IDX_W-1:0]  o_idx,
  output logic [ADDR_W-1:0] o_offset
);

  logic [ADDR_W-1:0] base_k;
  logic [ADDR_W-1:0] limit_k;

  // Scan from the top so the lowest matching region is the last to write.
  always_comb begin
    o_hit    = 1'b0;
    o_sel    = '0;
    o_idx    = '0;
    o_offset = '0;
    base_k   = '0;
    limit_k  = '0;
    for (int k = N_TGT - 1; k >= 0; k--) begin
      base_k  = TGT_BASE[k*ADDR_W +: ADDR_W];
      limit_k = TGT_LIMIT[k*ADDR_W +: ADDR_W];
      if ((i_addr >= base_k) && (i_addr < limit_k)) begin
        o_hit    = 1'b1;
        o_sel    = '0;
        o_sel[k] = 1'b1;
        o_idx    = IDX_W'(k);
        o_offset = i_addr - base_k;
      end
    end
  end

endmodule

// File: rtl/mem_xbar_hs.sv
// Single-initiator N-target memory crossbar with request/grant handshake and
// one outstanding transaction. Response timeout guarded by MEM_XBAR_HS_TIMEOUT_EN.
module mem_xbar_hs
  import mem_xbar_pkg::*;
#(
  parameter int                      N_TGT     = 2,
  parameter int                      ADDR_W    = DEF_ADDR_W,
  parameter int                      DATA_W    = DEF_DATA_W,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE  = '0,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_LIMIT = '0,
  parameter int                      TIMEOUT   = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_xbar_hs_if.slave   bus
);

  localparam int IDX_W = (N_TGT > 1) ? clog2(N_TGT) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic              wren_q, wren_d;

  logic              dec_hit;
  logic [N_TGT-1:0]  dec_sel;
  logic [IDX_W-1:0]  dec_idx;
  logic [ADDR_W-1:0] dec_off;

  logic              idle_req;
  logic              gnt_hit;
  logic              gnt_err;
  logic              t_rv;
  logic [DATA_W-1:0] t_rd;
  logic              timeout;

  mem_xbar_hs_dec #(
    .N_TGT     (N_TGT),
    .ADDR_W    (ADDR_W),
    .TGT_BASE  (TGT_BASE),
    .TGT_LIMIT (TGT_LIMIT)
  ) u_dec (
    .i_addr   (bus.i_addr),
    .o_hit    (dec_hit),
    .o_sel    (dec_sel),
    .o_idx    (dec_idx),
    .o_offset (dec_off)
  );

  assign idle_req = (state_q == ST_IDLE) && bus.i_req;
  assign gnt_hit  = idle_req && dec_hit && (|(bus.i_t_gnt & dec_sel));
  assign gnt_err  = idle_req && !dec_hit;
  // Only the latched target's response channel is ever observed.
  assign t_rv     = bus.i_t_rvalid[sel_q];
  assign t_rd     = bus.i_t_rdata[int'(sel_q)*DATA_W +: DATA_W];

`ifdef MEM_XBAR_HS_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires in the TIMEOUT-th cycle after the grant.
  assign timeout = (state_q == ST_RESP) &&
                   (({1'b0, cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_hit) begin
      cnt_d = '0;
    end else if (state_q == ST_RESP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wren_q  <= wren_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wren_d  = wren_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_hit) begin
          state_d = ST_RESP;
          sel_d   = dec_idx;
          wren_d  = bus.i_wren;
        end else if (gnt_err) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP: begin
        if (t_rv || timeout) state_d = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_gnt    = 1'b0;
    bus.o_rvalid = 1'b0;
    bus.o_rdata  = '0;
    bus.o_err    = 1'b0;
    bus.o_t_req  = '0;
    bus.o_t_addr = '0;
    bus.o_t_wren = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          if (dec_hit) begin
            bus.o_t_req  = dec_sel;
            bus.o_t_addr = dec_off;
            bus.o_t_wren = bus.i_wren;
            bus.o_gnt    = gnt_hit;
          end else begin
            bus.o_gnt    = 1'b1;
          end
        end
      end
      ST_RESP: begin
        // A real response in the timeout cycle takes priority over the error.
        if (t_rv) begin
          bus.o_rvalid = 1'b1;
          bus.o_rdata  = wren_q ? '0 : t_rd;
        end else if (timeout) begin
          bus.o_rvalid = 1'b1;
          bus.o_err    = 1'b1;
        end
      end
      ST_ERR: begin
        bus.o_rvalid = 1'b1;
        bus.o_err    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_t_data = bus.i_data;
  assign bus.o_t_mask = bus.i_mask;

endmodule
